// File: rtl/uart_receiver.sv
// 8-bit UART receiver with 2-flop input synchronizer, one-byte holding register and error pulses.
// Optional even-parity bit enabled by defining UART_RECEIVER_PARITY_EN.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

  logic       rx_meta_q, rxs_q;
  logic [2:0] state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       parity_err_q, parity_err_d;
`ifdef UART_RECEIVER_PARITY_EN
  logic       par_q, par_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
    par_d        = par_q;
`endif
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StParity: begin
`ifdef UART_RECEIVER_PARITY_EN
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          par_d   = rxs_q;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs_q) begin
            // Back to idle on the stop-sample edge so an immediate start bit is caught.
            state_d = StIdle;
            if (!rx_valid_q || rx_ready) begin
              rx_byte_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
`ifdef UART_RECEIVER_PARITY_EN
            parity_err_d = (^shift_q) ^ par_q;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StBreak: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rxs_q        <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RECEIVER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frame-level model queues expected bytes and error pulses.
module tb_uart_receiver;
  localparam int unsigned Cpb = 16;
  localparam int EFrame = 0;
  localparam int EOverrun = 1;
  localparam int EParity = 2;

  logic       clk = 1'b0;
  logic       rst, rx, rx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err, overrun, parity_err;

  logic [7:0] exp_data_q[$];
  int         exp_err_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       model_full = 1'b0;

  uart_receiver #(.CLKS_PER_BIT(Cpb)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_err(input string name, input int kind);
    if (exp_err_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected pulse (kind %0d), none expected at %0t", name, kind, $time);
    end else begin
      check(name, kind, exp_err_q.pop_front());
    end
  endtask

  // Monitor: compares every presented pulse and every accepted byte against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) pop_err("frame_err", EFrame);
      if (overrun) pop_err("overrun", EOverrun);
      if (parity_err) pop_err("parity_err", EParity);
      if (rx_valid && rx_ready) begin
        if (exp_data_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_byte: unexpected byte 0x%0h, none expected at %0t", rx_byte, $time);
        end else begin
          check("rx_byte", rx_byte, exp_data_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(Cpb);
  endtask

  // Frame-level reference: outcome decided from stop bit, holding state and consumer readiness.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    if (!stop_bit) begin
      exp_err_q.push_back(EFrame);
    end else begin
      if (model_full && !rx_ready) begin
        exp_err_q.push_back(EOverrun);
      end else begin
        exp_data_q.push_back(d);
        if (!rx_ready) model_full = 1'b1;
      end
`ifdef UART_RECEIVER_PARITY_EN
      if (par_flip) exp_err_q.push_back(EParity);
`else
      if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RECEIVER_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    model_frame(d, stop_bit, par_flip);
    send_bit(stop_bit);
    if (!stop_bit) begin
      rx = 1'b1;
      tick(Cpb);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_byte"}, rx_byte, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_parity_err"}, parity_err, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    int         budget;
    rx       = 1'b1;
    rx_ready = 1'b1;
    rst      = 1'b1;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(5);

    send_frame(8'hA5, 1'b1, 1'b0);
    tick(Cpb);

    // Short low glitch must be rejected at the mid-start sample.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * Cpb);
    check("glitch_rx_valid", rx_valid, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b0);
    tick(2 * Cpb);
    check("after_break_rx_valid", rx_valid, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    tick(Cpb);

    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        rx = 1'b0;
        tick(int'($urandom_range(1, 4)));
        rx = 1'b1;
        tick(Cpb);
      end
      send_frame(d, ($urandom_range(0, 5) != 0), 1'b0);
      tick(int'($urandom_range(0, 2 * Cpb)));
    end
    tick(2 * Cpb);

    // Holding register full: second back-to-back byte is dropped.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(Cpb);
    check("hold_rx_valid", rx_valid, 1'b1);
    check("hold_rx_byte", rx_byte, 8'h11);
    rx_ready = 1'b1;
    tick(1);
    rx_ready   = 1'b0;
    model_full = 1'b0;
    check("consumed_rx_valid", rx_valid, 1'b0);
    tick(2);
    rx_ready = 1'b1;

    // Reset during data bit 4 abandons the frame.
    d = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    tick(5);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2 * Cpb);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(Cpb);

`ifdef UART_RECEIVER_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    tick(Cpb);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(Cpb);
`endif

    budget = 4 * Cpb;
    while ((exp_data_q.size() != 0 || exp_err_q.size() != 0) && budget > 0) begin
      tick(1);
      budget--;
    end
    check("pending_bytes", exp_data_q.size(), 0);
    check("pending_errors", exp_err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
